// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size codes, FSM states and alignment check for dmem_unit
package dmem_pkg;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Halves must sit on even bytes, words on 4-byte boundaries.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SZ_HALF) && addr_lo[0]) ||
               ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - MEM-stage request/response bundle for dmem_unit
interface dmem_if;

    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [1:0]  req_read_i;
    logic [1:0]  req_write_i;
    logic        req_unsigned_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        err_o;

    modport master (
        output req_addr_i, req_wdata_i, req_read_i, req_write_i, req_unsigned_i,
        input  stall_o, rdata_o, rdata_valid_o, err_o
    );

    modport slave (
        input  req_addr_i, req_wdata_i, req_read_i, req_write_i, req_unsigned_i,
        output stall_o, rdata_o, rdata_valid_o, err_o
    );

endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - little-endian byte-lane steering and load extension
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    // Replicate store data across lanes; shift the addressed lane down and extend it.
    always_comb begin
        byte_en   = 4'b0000;
        wword     = wdata;
        shifted   = rword >> {addr_lo, 3'b000};
        rdata_ext = rword;
        case (size)
            SZ_BYTE: begin
                byte_en   = 4'b0001 << addr_lo;
                wword     = {4{wdata[7:0]}};
                rdata_ext = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword     = {2{wdata[15:0]}};
                rdata_ext = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            end
            SZ_WORD: begin
                byte_en   = 4'b1111;
                wword     = wdata;
                rdata_ext = rword;
            end
            default: begin
                byte_en = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_unit.sv
// rtl/dmem_unit.sv - wait-stated word RAM with byte/half/word loads and stores
module dmem_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    dmem_if.slave       bus,
    output logic [31:0] load_count_o,
    output logic [31:0] store_count_o
);

    localparam int         DEPTH   = 2 ** ADDR_WIDTH;
    localparam int         AW      = ADDR_WIDTH + 2;
    localparam logic [3:0] WS_LAST = WAIT_STATES[3:0];

    state_e          state;
    logic [3:0]      cnt;

    logic [AW-1:0]   lat_addr;
    logic [31:0]     lat_wdata;
    logic [1:0]      lat_read;
    logic [1:0]      lat_write;
    logic            lat_unsigned;

    logic [AW-1:0]   eff_addr;
    logic [31:0]     eff_wdata;
    logic [1:0]      eff_read;
    logic [1:0]      eff_write;
    logic [1:0]      eff_size;
    logic            eff_unsigned;

    logic [1:0]      live_size;
    logic            req_present;
    logic            req_illegal;
    logic            req_legal;
    logic            execute;

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]     mem [DEPTH];
    logic [31:0]     rword;
    logic [31:0]     merged;
    logic [3:0]      byte_en;
    logic [31:0]     wword;
    logic [31:0]     rdata_ext;

    // Upper address bits are deliberately dropped so the RAM aliases.
    logic            unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr_i[31:AW];

    // Pick live inputs in IDLE, the latched request while waiting; classify and stall.
    always_comb begin
        if (state == ST_WAIT) begin
            eff_addr     = lat_addr;
            eff_wdata    = lat_wdata;
            eff_read     = lat_read;
            eff_write    = lat_write;
            eff_unsigned = lat_unsigned;
        end else begin
            eff_addr     = bus.req_addr_i[AW-1:0];
            eff_wdata    = bus.req_wdata_i;
            eff_read     = bus.req_read_i;
            eff_write    = bus.req_write_i;
            eff_unsigned = bus.req_unsigned_i;
        end
        eff_size    = (eff_read != SZ_NONE) ? eff_read : eff_write;
        live_size   = (bus.req_read_i != SZ_NONE) ? bus.req_read_i : bus.req_write_i;
        req_present = (bus.req_read_i != SZ_NONE) || (bus.req_write_i != SZ_NONE);
        req_illegal = ((bus.req_read_i != SZ_NONE) && (bus.req_write_i != SZ_NONE)) ||
                      is_misaligned(live_size, bus.req_addr_i[1:0]);
        req_legal   = (state == ST_IDLE) && req_present && !req_illegal;
        execute     = ((state == ST_WAIT) && (cnt == WS_LAST)) ||
                      (req_legal && (WS_LAST == 4'd0));
        bus.stall_o = (req_legal && (WS_LAST != 4'd0)) ||
                      ((state == ST_WAIT) && (cnt != WS_LAST));
    end

    assign word_idx = eff_addr[AW-1:2];
    assign rword    = mem[word_idx];

    dmem_lane_align u_align (
        .size        (eff_size),
        .addr_lo     (eff_addr[1:0]),
        .is_unsigned (eff_unsigned),
        .wdata       (eff_wdata),
        .rword       (rword),
        .byte_en     (byte_en),
        .wword       (wword),
        .rdata_ext   (rdata_ext)
    );

    // Read-modify-write word: enabled lanes take store data, the rest keep RAM contents.
    always_comb begin
        merged = rword;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                merged[8*i +: 8] = wword[8*i +: 8];
            end
        end
    end

    // RAM write at the completion edge; a reset on that edge abandons the store.
    always_ff @(posedge clk_i) begin
        if (!rst_i && execute && (eff_write != SZ_NONE)) begin
            mem[word_idx] <= merged;
        end
    end

    // Access FSM, response registers and completion counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state             <= ST_IDLE;
            cnt               <= 4'd0;
            lat_addr          <= '0;
            lat_wdata         <= 32'd0;
            lat_read          <= SZ_NONE;
            lat_write         <= SZ_NONE;
            lat_unsigned      <= 1'b0;
            bus.rdata_o       <= 32'd0;
            bus.rdata_valid_o <= 1'b0;
            bus.err_o         <= 1'b0;
            load_count_o      <= 32'd0;
            store_count_o     <= 32'd0;
        end else begin
            bus.rdata_valid_o <= 1'b0;
            bus.err_o         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_present && req_illegal) begin
                        bus.err_o <= 1'b1;
                    end else if (req_legal && (WS_LAST != 4'd0)) begin
                        lat_addr     <= bus.req_addr_i[AW-1:0];
                        lat_wdata    <= bus.req_wdata_i;
                        lat_read     <= bus.req_read_i;
                        lat_write    <= bus.req_write_i;
                        lat_unsigned <= bus.req_unsigned_i;
                        cnt          <= 4'd1;
                        state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != WS_LAST) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        cnt   <= 4'd0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            if (execute) begin
                if (eff_read != SZ_NONE) begin
                    bus.rdata_o       <= rdata_ext;
                    bus.rdata_valid_o <= 1'b1;
                    load_count_o      <= load_count_o + 32'd1;
                end
                if (eff_write != SZ_NONE) begin
                    store_count_o <= store_count_o + 32'd1;
                end
            end
        end
    end

endmodule
